// File: rtl/nios2_proc_nios2_cpu_ocimem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// nios2_proc_nios2_cpu_ocimem_arbiter_pkg
// Shared definitions for the OCI debug-memory arbiter: FSM state encoding,
// grant identifiers, default widths and the field layout of the JTAG jdo bus.
// ---------------------------------------------------------------------------
package nios2_proc_nios2_cpu_ocimem_arbiter_pkg;

   localparam int ADDR_W_DEF    = 8;
   localparam int DATA_W_DEF    = 32;

   // jdo field layout
   localparam int JDO_W         = 38;
   localparam int JDO_ADDR_LSB  = 0;
   localparam int JDO_ADDR_MSB  = 7;
   localparam int JDO_WDATA_LSB = 0;
   localparam int JDO_WDATA_MSB = 31;
   localparam int JDO_WR_BIT    = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_AV_ACC = 3'd1,
      ST_AV_RD  = 3'd2,
      ST_JT_ACC = 3'd3,
      ST_JT_RD  = 3'd4
   } state_e;

   typedef enum logic {
      GRANT_AV = 1'b0,
      GRANT_JT = 1'b1
   } grant_e;

   function automatic logic is_jtag_state(input state_e s);
      return (s == ST_JT_ACC) || (s == ST_JT_RD);
   endfunction

endpackage

// File: rtl/nios2_proc_nios2_cpu_ocimem_rr_arb.sv
// ---------------------------------------------------------------------------
// nios2_proc_nios2_cpu_ocimem_rr_arb
// Two-requester round-robin arbiter (Avalon vs JTAG).
//   clk, reset_n  : clock, async active-low reset
//   arb_en_i      : arbitration allowed this cycle (owner FSM is idle)
//   req_av_i      : Avalon requester pending
//   req_jt_i      : JTAG requester pending
//   gnt_av_o      : Avalon granted (combinational, only when arb_en_i)
//   gnt_jt_o      : JTAG granted   (combinational, only when arb_en_i)
// On a tie the requester that did not win last time is granted. The history
// resets to JTAG so that Avalon wins the first tie after reset.
// ---------------------------------------------------------------------------
module nios2_proc_nios2_cpu_ocimem_rr_arb
   import nios2_proc_nios2_cpu_ocimem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic arb_en_i,
   input  logic req_av_i,
   input  logic req_jt_i,
   output logic gnt_av_o,
   output logic gnt_jt_o
);

   grant_e last_grant_q;

   always_comb begin
      gnt_av_o = 1'b0;
      gnt_jt_o = 1'b0;
      if (arb_en_i) begin
         if (req_av_i && req_jt_i) begin
            gnt_av_o = (last_grant_q == GRANT_JT);
            gnt_jt_o = (last_grant_q == GRANT_AV);
         end else begin
            gnt_av_o = req_av_i;
            gnt_jt_o = req_jt_i;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= GRANT_JT;
      end else if (gnt_av_o) begin
         last_grant_q <= GRANT_AV;
      end else if (gnt_jt_o) begin
         last_grant_q <= GRANT_JT;
      end
   end

endmodule

// File: rtl/nios2_proc_nios2_cpu_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// nios2_proc_nios2_cpu_ocimem_arbiter
// Arbitrates the single-port OCI debug RAM between the Avalon debug_mem slave
// and the JTAG debug path.
//   clk, reset_n                 : clock, async active-low reset
//   take_action_ocimem_a         : JTAG address-load strobe (jdo[7:0])
//   take_action_ocimem_b         : JTAG access strobe (jdo[32] wr, jdo[31:0] data)
//   jdo                          : JTAG data bus
//   av_address/read/write/...    : Avalon command, held until accepted
//   av_waitrequest, av_readdata  : Avalon completion / read data
//   ram_addr/we/be/wdata         : RAM request, ram_rdata has 1-cycle latency
//   MonDReg                      : data returned by the last JTAG read
//   jtag_busy, jtag_overrun      : JTAG pending/in-flight, sticky strobe error
//   dbg_state, dbg_jtag_addr     : FSM state and JTAG address for observation
//
// Handshake: an Avalon command (av_read or av_write) is a request that stays
// asserted with stable address/data until the cycle av_waitrequest is low;
// that cycle is the acceptance/completion. JTAG strobes are single-cycle
// pulses with no backpressure: a strobe that cannot be accepted is dropped
// and flagged in jtag_overrun.
// ---------------------------------------------------------------------------
module nios2_proc_nios2_cpu_ocimem_arbiter
   import nios2_proc_nios2_cpu_ocimem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [JDO_W-1:0]  jdo,
   input  logic [ADDR_W-1:0] av_address,
   input  logic              av_read,
   input  logic              av_write,
   input  logic [DATA_W-1:0] av_writedata,
   input  logic [3:0]        av_byteenable,
   output logic              av_waitrequest,
   output logic [DATA_W-1:0] av_readdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [3:0]        ram_be,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] MonDReg,
   output logic              jtag_busy,
   output logic              jtag_overrun,
   output state_e            dbg_state,
   output logic [ADDR_W-1:0] dbg_jtag_addr
);

   state_e              state_q;
   logic                jtag_pend_q;
   logic [ADDR_W-1:0]   jtag_addr_q;
   logic [JDO_WR_BIT:0] jtag_cmd_q;
   logic [DATA_W-1:0]   mon_dreg_q;
   logic                overrun_q;

   logic in_jt, a_accept, a_reject, b_accept, b_reject, jt_done;
   logic gnt_av, gnt_jt;
   logic jdo_unused;

   assign jdo_unused = ^jdo[JDO_W-1:JDO_WR_BIT+1];

   assign in_jt    = is_jtag_state(state_q);
   assign a_accept = take_action_ocimem_a && !in_jt;
   assign a_reject = take_action_ocimem_a && in_jt;
   assign b_accept = take_action_ocimem_b && !jtag_pend_q && !in_jt;
   assign b_reject = take_action_ocimem_b && !b_accept;
   // Last cycle of a JTAG access: write completes in JT_ACC, read in JT_RD.
   assign jt_done  = ((state_q == ST_JT_ACC) && jtag_cmd_q[JDO_WR_BIT]) ||
                     (state_q == ST_JT_RD);

   nios2_proc_nios2_cpu_ocimem_rr_arb u_rr_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .arb_en_i (state_q == ST_IDLE),
      .req_av_i (av_read || av_write),
      .req_jt_i (jtag_pend_q),
      .gnt_av_o (gnt_av),
      .gnt_jt_o (gnt_jt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         jtag_pend_q <= 1'b0;
         jtag_addr_q <= '0;
         jtag_cmd_q  <= '0;
         mon_dreg_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_av)      state_q <= ST_AV_ACC;
               else if (gnt_jt) state_q <= ST_JT_ACC;
            end
            ST_AV_ACC: state_q <= av_write ? ST_IDLE : ST_AV_RD;
            ST_AV_RD:  state_q <= ST_IDLE;
            ST_JT_ACC: state_q <= jtag_cmd_q[JDO_WR_BIT] ? ST_IDLE : ST_JT_RD;
            ST_JT_RD: begin
               mon_dreg_q <= ram_rdata;
               state_q    <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase

         // Address-load strobes are rejected while in a JT_* state, so the
         // post-access increment and a load can never collide.
         if (jt_done) begin
            jtag_pend_q <= 1'b0;
            jtag_addr_q <= jtag_addr_q + ADDR_W'(1);
         end else if (a_accept) begin
            jtag_addr_q <= ADDR_W'(jdo[JDO_ADDR_MSB:JDO_ADDR_LSB]);
         end

         if (b_accept) begin
            jtag_pend_q <= 1'b1;
            jtag_cmd_q  <= jdo[JDO_WR_BIT:0];
         end

         if (a_reject || b_reject) overrun_q <= 1'b1;
      end
   end

   // RAM/Avalon outputs are a pure decode of the registered state; IDLE
   // decodes to the quiescent values, which also covers reset.
   always_comb begin
      ram_addr       = '0;
      ram_be         = '0;
      ram_wdata      = '0;
      ram_we         = 1'b0;
      av_waitrequest = 1'b1;
      av_readdata    = '0;
      case (state_q)
         ST_AV_ACC: begin
            ram_addr       = av_address;
            ram_be         = av_byteenable;
            ram_wdata      = av_writedata;
            ram_we         = av_write;
            av_waitrequest = !av_write;
         end
         ST_AV_RD: begin
            av_readdata    = ram_rdata;
            av_waitrequest = 1'b0;
         end
         ST_JT_ACC: begin
            ram_addr  = jtag_addr_q;
            ram_be    = 4'hF;
            ram_wdata = DATA_W'(jtag_cmd_q[JDO_WDATA_MSB:JDO_WDATA_LSB]);
            ram_we    = jtag_cmd_q[JDO_WR_BIT];
         end
         default: ;
      endcase
   end

   assign MonDReg       = mon_dreg_q;
   assign jtag_busy     = jtag_pend_q || in_jt;
   assign jtag_overrun  = overrun_q;
   assign dbg_state     = state_q;
   assign dbg_jtag_addr = jtag_addr_q;

endmodule

// File: tb/tb_nios2_proc_nios2_cpu_ocimem_arbiter.sv
module tb_nios2_proc_nios2_cpu_ocimem_arbiter;
   import nios2_proc_nios2_cpu_ocimem_arbiter_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic        take_a, take_b;
   logic [37:0] jdo;
   logic [7:0]  av_address;
   logic        av_read, av_write;
   logic [31:0] av_writedata;
   logic [3:0]  av_byteenable;
   logic        av_waitrequest;
   logic [31:0] av_readdata;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] MonDReg;
   logic        jtag_busy, jtag_overrun;
   state_e      dbg_state;
   logic [7:0]  dbg_jtag_addr;

   nios2_proc_nios2_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .take_action_ocimem_a (take_a),
      .take_action_ocimem_b (take_b),
      .jdo                  (jdo),
      .av_address           (av_address),
      .av_read              (av_read),
      .av_write             (av_write),
      .av_writedata         (av_writedata),
      .av_byteenable        (av_byteenable),
      .av_waitrequest       (av_waitrequest),
      .av_readdata          (av_readdata),
      .ram_addr             (ram_addr),
      .ram_we               (ram_we),
      .ram_be               (ram_be),
      .ram_wdata            (ram_wdata),
      .ram_rdata            (ram_rdata),
      .MonDReg              (MonDReg),
      .jtag_busy            (jtag_busy),
      .jtag_overrun         (jtag_overrun),
      .dbg_state            (dbg_state),
      .dbg_jtag_addr        (dbg_jtag_addr)
   );

   // ---------------- RAM behind the DUT (registered read) ----------------
   function automatic logic [31:0] seed_word(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
   endfunction

   logic [31:0] mem [256];
   logic        ram_init;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
      end else if (ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= mem[ram_addr];
   end

   // ---------------- reference model + scoreboard ----------------
   logic [31:0] ref_mem [256];
   logic [7:0]  ref_jaddr;
   logic [43:0] wr_exp_q  [$];   // {be, addr, data} of each RAM write, in order
   logic [32:0] av_exp_q  [$];   // {is_read, readdata} of each Avalon completion
   logic [31:0] mon_exp_q [$];   // MonDReg after each JTAG read
   int compared = 0;
   int mismatched = 0;
   int unsigned av_done_cyc, jt_done_cyc;

   function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function void ref_write(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
      for (int b = 0; b < 4; b++)
         if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
   endfunction

   // monitor: compares every DUT output event against the queues
   logic [43:0] mon_we;
   logic [32:0] mon_av;
   logic [31:0] mon_md;
   logic        jt_rd_prev = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            jt_rd_prev = 1'b0;
         end else begin
            if (ram_we) begin
               if (wr_exp_q.size() == 0) begin
                  check("unexpected_ram_write", 64'(ram_we), 64'd0);
               end else begin
                  mon_we = wr_exp_q.pop_front();
                  check("ram_write", 64'({ram_be, ram_addr, ram_wdata}), 64'(mon_we));
               end
            end
            if (!av_waitrequest) begin
               if (av_exp_q.size() == 0) begin
                  check("unexpected_av_done", 64'(av_waitrequest), 64'd1);
               end else begin
                  mon_av = av_exp_q.pop_front();
                  if (mon_av[32]) check("av_readdata", 64'(av_readdata), 64'(mon_av[31:0]));
                  else            check("av_write_we", 64'(ram_we), 64'd1);
               end
            end
            if (jt_rd_prev) begin
               if (mon_exp_q.size() == 0) begin
                  check("unexpected_jtag_read", 64'(jt_rd_prev), 64'd0);
               end else begin
                  mon_md = mon_exp_q.pop_front();
                  check("MonDReg", 64'(MonDReg), 64'(mon_md));
               end
            end
            jt_rd_prev = (dbg_state == ST_JT_RD);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_av(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (av_waitrequest && n < 50);
      check("av_timeout", 64'(av_waitrequest), 64'd0);
      av_done_cyc = cyc;
   endtask

   task automatic wait_jt();
      int n = 0;
      do begin @(negedge clk); n++; end while (jtag_busy && n < 50);
      check("jtag_timeout", 64'(jtag_busy), 64'd0);
      jt_done_cyc = cyc;
   endtask

   task automatic av_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                        input bit chk_lat);
      int n;
      @(posedge clk); #1;
      av_address = a; av_writedata = d; av_byteenable = be; av_write = 1'b1;
      wr_exp_q.push_back({be, a, d});
      av_exp_q.push_back({1'b0, 32'h0});
      ref_write(a, be, d);
      wait_av(n);
      if (chk_lat) check("av_write_latency", 64'(n), 64'd2);
      @(posedge clk); #1;
      av_write = 1'b0;
   endtask

   task automatic av_rd(input logic [7:0] a, input bit chk_lat);
      int n;
      @(posedge clk); #1;
      av_address = a; av_byteenable = 4'hF; av_read = 1'b1;
      av_exp_q.push_back({1'b1, ref_mem[a]});
      wait_av(n);
      if (chk_lat) check("av_read_latency", 64'(n), 64'd3);
      @(posedge clk); #1;
      av_read = 1'b0;
   endtask

   task automatic jtag_load(input logic [7:0] a);
      @(posedge clk); #1;
      take_a = 1'b1; jdo = {30'b0, a};
      ref_jaddr = a;
      @(posedge clk); #1;
      take_a = 1'b0;
   endtask

   task automatic jtag_acc(input logic wr, input logic [31:0] d);
      @(posedge clk); #1;
      take_b = 1'b1; jdo = {5'b0, wr, d};
      if (wr) begin
         wr_exp_q.push_back({4'hF, ref_jaddr, d});
         ref_write(ref_jaddr, 4'hF, d);
      end else begin
         mon_exp_q.push_back(ref_mem[ref_jaddr]);
      end
      ref_jaddr++;
      @(posedge clk); #1;
      take_b = 1'b0;
      wait_jt();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   logic [7:0] ov_addr;
   initial begin
      take_a = 0; take_b = 0; jdo = '0;
      av_address = '0; av_read = 0; av_write = 0; av_writedata = '0; av_byteenable = '0;
      ram_init = 1'b1;
      ref_jaddr = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);

      repeat (2) @(negedge clk);
      check("rst_waitrequest", 64'(av_waitrequest), 64'd1);
      check("rst_ram_we",      64'(ram_we), 64'd0);
      check("rst_ram_addr",    64'(ram_addr), 64'd0);
      check("rst_ram_be",      64'(ram_be), 64'd0);
      check("rst_ram_wdata",   64'(ram_wdata), 64'd0);
      check("rst_av_readdata", 64'(av_readdata), 64'd0);
      check("rst_MonDReg",     64'(MonDReg), 64'd0);
      check("rst_jtag_busy",   64'(jtag_busy), 64'd0);
      check("rst_overrun",     64'(jtag_overrun), 64'd0);
      check("rst_state",       64'(dbg_state), 64'(ST_IDLE));
      check("rst_jtag_addr",   64'(dbg_jtag_addr), 64'd0);
      @(posedge clk); #1;
      ram_init = 1'b0;
      reset_n  = 1'b1;

      // First tie after reset: Avalon wins, JTAG follows.
      jtag_load(8'h40);
      fork
         jtag_acc(1'b0, 32'h0);
         begin @(posedge clk); av_wr(8'h20, 32'h0BADF00D, 4'hF, 1'b1); end
      join
      check("tie1_av_first", 64'(av_done_cyc < jt_done_cyc), 64'd1);

      // Avalon served alone, so the next tie goes to JTAG.
      av_rd(8'h20, 1'b1);
      fork
         jtag_acc(1'b1, 32'hCAFE0001);
         begin @(posedge clk); av_rd(8'h30, 1'b0); end
      join
      check("tie2_jt_first", 64'(jt_done_cyc < av_done_cyc), 64'd1);

      // JTAG write to 0x10: RAM write two cycles after the strobe.
      jtag_load(8'h10);
      @(posedge clk); #1;
      take_b = 1'b1; jdo = {5'b0, 1'b1, 32'hDEADBEEF};
      wr_exp_q.push_back({4'hF, 8'h10, 32'hDEADBEEF});
      ref_write(8'h10, 4'hF, 32'hDEADBEEF);
      ref_jaddr++;
      @(negedge clk);
      check("jt_wr_c0_we", 64'(ram_we), 64'd0);
      @(posedge clk); #1;
      take_b = 1'b0;
      @(negedge clk);
      check("jt_wr_c1_we", 64'(ram_we), 64'd0);
      @(negedge clk);
      check("jt_wr_c2_req", 64'({ram_we, ram_addr, ram_be}), 64'({1'b1, 8'h10, 4'hF}));
      wait_jt();
      check("jtag_addr_inc", 64'(dbg_jtag_addr), 64'h11);

      // Avalon read of the JTAG-written word, 3-cycle latency.
      av_rd(8'h10, 1'b1);

      // JTAG read at 0xFF wraps the address.
      av_wr(8'hFF, 32'h13572468, 4'hF, 1'b1);
      jtag_load(8'hFF);
      jtag_acc(1'b0, 32'h0);
      check("jtag_addr_wrap", 64'(dbg_jtag_addr), 64'd0);

      // Randomized serialized traffic.
      repeat (60) begin
         case ($urandom_range(0, 3))
            0:       av_wr(8'($urandom), $urandom, 4'($urandom_range(1, 15)), 1'b1);
            1:       av_rd(8'($urandom), 1'b1);
            2:       jtag_load(8'($urandom));
            default: jtag_acc(1'($urandom), $urandom);
         endcase
      end

      // Second access strobe while busy: dropped and flagged.
      check("pre_overrun", 64'(jtag_overrun), 64'd0);
      ov_addr = ref_jaddr;
      @(posedge clk); #1;
      take_b = 1'b1; jdo = {5'b0, 1'b1, 32'h11112222};
      wr_exp_q.push_back({4'hF, ref_jaddr, 32'h11112222});
      ref_write(ref_jaddr, 4'hF, 32'h11112222);
      ref_jaddr++;
      @(posedge clk); #1;
      jdo = {5'b0, 1'b1, 32'h33334444};
      @(posedge clk); #1;
      take_b = 1'b0;
      wait_jt();
      check("overrun_set", 64'(jtag_overrun), 64'd1);
      check("overrun_one_access", 64'(dbg_jtag_addr), 64'(ref_jaddr));
      av_rd(ov_addr, 1'b1);
      repeat (5) @(negedge clk);
      check("overrun_sticky", 64'(jtag_overrun), 64'd1);

      // Reset in the middle of an Avalon read.
      @(posedge clk); #1;
      av_address = 8'h55; av_read = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_av_acc", 64'(dbg_state), 64'(ST_AV_ACC));
      #2 reset_n = 1'b0;
      #1;
      check("reset_waitrequest", 64'(av_waitrequest), 64'd1);
      check("reset_state_idle",  64'(dbg_state), 64'(ST_IDLE));
      check("reset_ram_we",      64'(ram_we), 64'd0);
      av_read = 1'b0;
      ref_jaddr = '0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("overrun_cleared", 64'(jtag_overrun), 64'd0);
      av_rd(8'h55, 1'b1);

      repeat (10) @(negedge clk);
      check("queues_drained", 64'(wr_exp_q.size() + av_exp_q.size() + mon_exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
